// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, stable-count debouncer, rise/fall/press pulses.
// Define BUTTON_CONDITIONER_AUTO_REPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
   parameter int NUM_CH        = 5,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] press
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (NUM_CH < 1) begin : g_chk_num_ch
      $error("button_conditioner: NUM_CH must be >= 1");
   end
   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_chk_sync
      $error("button_conditioner: SYNC_STAGES must be 2..4");
   end
   if (STABLE_CYCLES < 1) begin : g_chk_stable
      $error("button_conditioner: STABLE_CYCLES must be >= 1");
   end
   if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_chk_repeat
      $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
   localparam int               REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);
`endif

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_level;
      logic                   r_rise;
      logic                   r_fall;
      logic                   r_press;
      logic                   w_sync_out;
      logic [CNT_W-1:0]       w_cnt_nxt;
      logic                   w_level_nxt;
      logic                   w_rise_nxt;
      logic                   w_fall_nxt;
      logic                   w_press_nxt;

      assign w_sync_out = r_sync[SYNC_STAGES-1];

      // Input synchroniser shift chain
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[ch]};
         end
      end

      // Debounce decision: level follows sync_out only after STABLE_CYCLES disagreeing cycles
      always_comb begin
         w_cnt_nxt   = '0;
         w_level_nxt = r_level;
         w_rise_nxt  = 1'b0;
         w_fall_nxt  = 1'b0;
         if (w_sync_out != r_level) begin
            if (r_cnt == CNT_LAST) begin
               w_level_nxt = w_sync_out;
               w_rise_nxt  = w_sync_out;
               w_fall_nxt  = ~w_sync_out;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end else begin
            w_cnt_nxt = '0;
         end
      end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      logic [REP_W-1:0] r_rep;
      logic             w_rep_hit;

      // r_rep counts down to the next repeat; it never sits at zero while the level is high
      assign w_rep_hit   = r_level & ~w_fall_nxt & (r_rep == REP_W'(1));
      assign w_press_nxt = w_rise_nxt | w_rep_hit;

      // Hold-to-repeat countdown, loaded on rise and reloaded on each repeat
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rep <= '0;
         end else if (w_rise_nxt) begin
            r_rep <= REP_DLY;
         end else if (!r_level || w_fall_nxt) begin
            r_rep <= '0;
         end else if (w_rep_hit) begin
            r_rep <= REP_PER;
         end else begin
            r_rep <= r_rep - REP_W'(1);
         end
      end
`else
      assign w_press_nxt = w_rise_nxt;
`endif

      // Debounce counter, level and pulse registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= 1'b0;
         end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_press <= w_press_nxt;
         end
      end

      assign level[ch] = r_level;
      assign rise[ch]  = r_rise;
      assign fall[ch]  = r_fall;
      assign press[ch] = r_press;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised scoreboard bench for button_conditioner with a cycle-level reference model.
// Honours BUTTON_CONDITIONER_AUTO_REPEAT_EN for the expected press stream.
module tb_button_conditioner;

   localparam int NCH = 5;
   localparam int SS  = 2;
   localparam int SC  = 4;
   localparam int RD  = 16;
   localparam int RP  = 8;

   logic           clk;
   logic           rst_n;
   logic [NCH-1:0] btn_in;
   logic [NCH-1:0] level;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] press;

   button_conditioner #(
      .NUM_CH        (NCH),
      .SYNC_STAGES   (SS),
      .STABLE_CYCLES (SC),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall),
      .press  (press)
   );

   typedef struct packed {
      logic [NCH-1:0] lvl;
      logic [NCH-1:0] rs;
      logic [NCH-1:0] fl;
      logic [NCH-1:0] pr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_rise[NCH];
   int   n_fall[NCH];
   int   n_press[NCH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: sync chain is a delay line, debounce is a run-length rule, repeat is age arithmetic
   initial begin : ref_model
      logic [NCH-1:0] hist[$];
      logic [NCH-1:0] m_lvl;
      logic [NCH-1:0] s;
      int             run[NCH];
      int             age[NCH];
      exp_t           e;
      m_lvl = '0;
      for (int i = 0; i < NCH; i++) begin
         run[i] = 0;
         age[i] = 0;
      end
      forever begin
         @(posedge clk);
         e = '0;
         if (!rst_n) begin
            hist = {};
            for (int k = 0; k < SS; k++) hist.push_back('0);
            m_lvl = '0;
            for (int i = 0; i < NCH; i++) begin
               run[i] = 0;
               age[i] = 0;
            end
         end else begin
            s = hist[0];
            for (int i = 0; i < NCH; i++) begin
               if (s[i] != m_lvl[i]) begin
                  run[i]++;
                  if (run[i] == SC) begin
                     m_lvl[i] = s[i];
                     run[i]   = 0;
                     if (s[i]) begin
                        e.rs[i] = 1'b1;
                        e.pr[i] = 1'b1;
                        age[i]  = 0;
                     end else begin
                        e.fl[i] = 1'b1;
                     end
                  end
               end else begin
                  run[i] = 0;
               end
               if (m_lvl[i] && !e.rs[i]) begin
                  age[i]++;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                  if ((age[i] >= RD) && (((age[i] - RD) % RP) == 0)) e.pr[i] = 1'b1;
`endif
               end
            end
            hist.push_back(btn_in);
            void'(hist.pop_front());
         end
         e.lvl = m_lvl;
         exp_q.push_back(e);
      end
   end

   // Monitor: pops one expected output set per clock and compares it with the DUT
   initial begin : monitor
      exp_t e;
      for (int i = 0; i < NCH; i++) begin
         n_rise[i]  = 0;
         n_fall[i]  = 0;
         n_press[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty at %0t: got no expectation, expected one per cycle", $time);
         end else begin
            e = exp_q.pop_front();
            check("level", level, e.lvl);
            check("rise",  rise,  e.rs);
            check("fall",  fall,  e.fl);
            check("press", press, e.pr);
         end
         for (int i = 0; i < NCH; i++) begin
            n_rise[i]  += int'(rise[i]);
            n_fall[i]  += int'(fall[i]);
            n_press[i] += int'(press[i]);
         end
      end
   end

   initial begin : stimulus
      int r0;
      int f0;
      int len;
      logic [NCH-1:0] zero_v;
      logic [NCH-1:0] ones_v;
      zero_v = '0;
      ones_v = '1;
      rst_n  = 1'b0;
      btn_in = 5'b11111;
      #1;
      check("reset_outputs", level | rise | fall | press, zero_v);
      cyc(3);

      // Held buttons across reset release: rise exactly on the 6th edge after release
      rst_n = 1'b1;
      for (int k = 0; k < SS + SC - 1; k++) begin
         @(posedge clk);
         #1;
         check("release_level_low", level, zero_v);
      end
      @(posedge clk);
      #1;
      check("release_level", level, ones_v);
      check("release_rise", rise, ones_v);
      @(posedge clk);
      #1;
      check("release_rise_single", rise, zero_v);
      cyc(10);
      btn_in = 5'b00000;
      cyc(12);

      // Clean press on channel 0
      btn_in = 5'b00001;
      cyc(20);
      btn_in = 5'b00000;
      cyc(12);

      // Bounce on channel 2: phases of 1..3 cycles, then steady high
      r0 = n_rise[2];
      f0 = n_fall[2];
      for (int p = 0; p < 6; p++) begin
         len = int'($urandom_range(1, 3));
         btn_in[2] = (p == 1 || p == 4) ? 1'b0 : 1'b1;
         cyc(len);
      end
      btn_in[2] = 1'b1;
      cyc(14);
      n_cmp++;
      if (n_rise[2] - r0 != 1) begin
         n_bad++;
         $display("FAIL bounce_rise_count: got %0d, expected 1", n_rise[2] - r0);
      end
      n_cmp++;
      if (n_fall[2] != f0) begin
         n_bad++;
         $display("FAIL bounce_fall_count: got %0d, expected 0", n_fall[2] - f0);
      end
      btn_in[2] = 1'b0;
      cyc(12);

      // Channels 1 and 3 together, released 10 cycles later
      btn_in = 5'b01010;
      cyc(10);
      btn_in = 5'b00000;
      cyc(12);

      // Random slowly-toggling activity on all channels
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 7) == 0) btn_in[i] = ~btn_in[i];
         end
         cyc(1);
      end
      btn_in = 5'b00000;
      cyc(12);

      // Long hold on channel 4, then a second hold with reset asserted mid-repeat
      btn_in = 5'b10000;
      cyc(70);
      btn_in = 5'b00000;
      cyc(12);
      btn_in = 5'b10000;
      for (int k = 0; k < 20 && !level[4]; k++) cyc(1);
      n_cmp++;
      if (!level[4]) begin
         n_bad++;
         $display("FAIL hold_rise_timeout: got level[4]=0, expected 1 within 20 cycles");
      end
      cyc(20);
      rst_n = 1'b0;
      #1;
      check("midhold_reset_outputs", level | rise | fall | press, zero_v);
      cyc(2);
      rst_n = 1'b1;
      cyc(45);
      btn_in = 5'b00000;
      cyc(12);

`ifndef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      for (int i = 0; i < NCH; i++) begin
         n_cmp++;
         if (n_press[i] != n_rise[i]) begin
            n_bad++;
            $display("FAIL press_eq_rise ch%0d: got %0d presses, expected %0d", i, n_press[i], n_rise[i]);
         end
      end
`endif

      cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
